// File: rtl/bist_pkg.sv
// Shared types and constants for the 6:3 counter BIST sequencer.
// Holds the FSM encoding, LFSR taps and the signature compaction step.
package bist_pkg;

  localparam int SIG_W = 3;
  localparam int TPG_W = 6;

  // x^6 + x^5 + 1: feedback is lfsr[5] ^ lfsr[4]
  localparam logic [TPG_W-1:0] LFSR6_TAPS = 6'b110000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_t;

  // One compaction step of the 3-bit signature with response m.
  function automatic logic [SIG_W-1:0] sig_next(input logic [SIG_W-1:0] s,
                                                input logic [SIG_W-1:0] m);
    logic [SIG_W-1:0] r;
    r[2] = m[2] ^ s[1];
    r[1] = m[1] ^ s[0] ^ s[2];
    r[0] = m[0] ^ s[2];
    return r;
  endfunction

endpackage

// File: rtl/bist_lfsr6.sv
// 6-bit maximal-length Fibonacci LFSR used as the BIST pattern generator.
// load has priority over en; reset clears to zero so LOAD must seed it.
module bist_lfsr6
  import bist_pkg::*;
#(
  parameter logic [TPG_W-1:0] SEED = 6'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [TPG_W-1:0] q
);

  logic [TPG_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = {lfsr_q[TPG_W-2:0], ^(lfsr_q & LFSR6_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: drives the 6:3 counter from an LFSR for NUM_PATTERNS cycles,
// compacts its responses into a 3-bit signature and compares it to GOLDEN_SIG.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int               NUM_PATTERNS = 63,
  parameter logic [TPG_W-1:0] LFSR_SEED    = 6'h01,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] cut_in,
  output logic [TPG_W-1:0] tpg_out,
  output logic             test_mode,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  bist_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             lfsr_load, lfsr_en;

  bist_lfsr6 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .q     (tpg_out)
  );

  // An abort wins over any work in the busy states, so nothing is captured
  // or advanced on the aborting edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          pass_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        pass_d = 1'b0;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_RUN;
          lfsr_load = 1'b1;
          sig_d     = '0;
          cnt_d     = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else begin
          lfsr_en = 1'b1;
          sig_d   = sig_next(sig_q, cut_in);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_COMPARE;
          end
        end
      end
      ST_COMPARE: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
          pass_d  = (sig_q == GOLDEN_SIG);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  assign test_mode = (state_q == ST_RUN);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign sig       = sig_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: a linear run-level model sets expectations,
// one negedge process compares them, plus directed literal checks.
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start, abort;
  logic [2:0] cut_in;
  logic [5:0] tpg_out;
  logic       test_mode, busy, done, pass;
  logic [2:0] sig;

  bist_sequencer #(.NUM_PATTERNS(63), .LFSR_SEED(6'h01), .GOLDEN_SIG(3'b000)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cut_in(cut_in),
    .tpg_out(tpg_out), .test_mode(test_mode), .busy(busy), .done(done),
    .pass(pass), .sig(sig));

  // Small-N instances for the boundary cases
  logic       no_abort;
  logic       st1, st2;
  logic [2:0] cut_ones;
  logic [5:0] tpg1, tpg2a, tpg2b;
  logic       tm1, tm2a, tm2b, busy1, busy2a, busy2b;
  logic       done1, done2a, done2b, pass1, pass2a, pass2b;
  logic [2:0] sig1, sig2a, sig2b;

  bist_sequencer #(.NUM_PATTERNS(1), .LFSR_SEED(6'h01), .GOLDEN_SIG(3'b111)) u_n1 (
    .clk(clk), .reset(reset), .start(st1), .abort(no_abort), .cut_in(cut_ones),
    .tpg_out(tpg1), .test_mode(tm1), .busy(busy1), .done(done1), .pass(pass1), .sig(sig1));
  bist_sequencer #(.NUM_PATTERNS(2), .LFSR_SEED(6'h01), .GOLDEN_SIG(3'b010)) u_n2a (
    .clk(clk), .reset(reset), .start(st2), .abort(no_abort), .cut_in(cut_ones),
    .tpg_out(tpg2a), .test_mode(tm2a), .busy(busy2a), .done(done2a), .pass(pass2a), .sig(sig2a));
  bist_sequencer #(.NUM_PATTERNS(2), .LFSR_SEED(6'h01), .GOLDEN_SIG(3'b011)) u_n2b (
    .clk(clk), .reset(reset), .start(st2), .abort(no_abort), .cut_in(cut_ones),
    .tpg_out(tpg2b), .test_mode(tm2b), .busy(busy2b), .done(done2b), .pass(pass2b), .sig(sig2b));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference rules straight from the block description
  function automatic logic [5:0] lfsr_step(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4]};
  endfunction
  function automatic logic [2:0] sig_step(input logic [2:0] s, input logic [2:0] m);
    return {m[2] ^ s[1], m[1] ^ s[0] ^ s[2], m[0] ^ s[2]};
  endfunction

  // Expectations for the main instance, valid for the current cycle
  logic       chk_en = 1'b0;
  logic       chk_tpg, chk_sig, chk_pass;
  logic       exp_busy, exp_done, exp_tm, exp_pass;
  logic [5:0] exp_tpg;
  logic [2:0] exp_sig;

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("test_mode", test_mode, exp_tm);
      if (chk_tpg)  check("tpg_out", tpg_out, exp_tpg);
      if (chk_sig)  check("sig", sig, exp_sig);
      if (chk_pass) check("pass", pass, exp_pass);
    end
  end

  logic [5:0] m_lfsr;
  logic [2:0] m_sig;
  logic [2:0] cut_seq [63];
  logic [5:0] tpg_log [63];
  int         done_edges, tm_cnt;

  task automatic set_idle_reset_values();
    exp_busy = 1'b0; exp_done = 1'b0; exp_tm = 1'b0; exp_pass = 1'b0;
    exp_tpg = 6'h00; exp_sig = 3'b000;
    chk_tpg = 1'b1; chk_sig = 1'b1; chk_pass = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tpg"}, tpg_out, 6'h00);
    check({tag, "_sig"}, sig, 3'b000);
    check({tag, "_tm"}, test_mode, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
  endtask

  // cut_mode: 0 = all-zero responses, 1 = fresh random, 2 = replay cut_seq.
  // stop_k >= 0 ends the run in RUN cycle stop_k by abort or by reset.
  // Called just after a clock edge with the DUT in IDLE or DONE.
  task automatic main_run(input int cut_mode, input bit with_abort,
                          input int stop_k, input bit stop_by_reset);
    logic [2:0] m;
    bit rnd;
    rnd = (cut_mode != 0);
    start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = rnd ? ($urandom_range(0, 1) == 1) : 1'b0; abort = 1'b0;
    done_edges = 0; tm_cnt = 0;
    exp_busy = 1'b1; exp_done = 1'b0; exp_tm = 1'b0;
    chk_tpg = 1'b0; chk_sig = 1'b0; chk_pass = 1'b0;
    m_lfsr = 6'h01; m_sig = 3'b000;
    @(posedge clk); #1; done_edges++;
    for (int k = 0; k < 63; k++) begin
      exp_tm = 1'b1; exp_tpg = m_lfsr; exp_sig = m_sig; exp_pass = 1'b0;
      chk_tpg = 1'b1; chk_sig = 1'b1; chk_pass = 1'b1;
      if (test_mode) tm_cnt++;
      tpg_log[k] = tpg_out;
      case (cut_mode)
        0: m = 3'b000;
        1: begin m = 3'($urandom_range(0, 7)); cut_seq[k] = m; end
        default: m = cut_seq[k];
      endcase
      cut_in = m;
      start = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (k == stop_k) begin
        start = 1'b0;
        if (stop_by_reset) begin
          #2;
          set_idle_reset_values();
          reset = 1'b1;
          #1 check_reset_outputs("async_reset");
          @(posedge clk); #1;
          reset = 1'b0;
          return;
        end
        abort = 1'b1;
      end
      @(posedge clk); #1; done_edges++;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_tm = 1'b0; exp_pass = 1'b0;
        chk_tpg = 1'b0; chk_sig = 1'b0; chk_pass = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        return;
      end
      m_sig = sig_step(m_sig, m);
      m_lfsr = lfsr_step(m_lfsr);
    end
    exp_tm = 1'b0; exp_tpg = m_lfsr; exp_sig = m_sig; exp_pass = 1'b0;
    if (test_mode) tm_cnt++;
    start = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
    @(posedge clk); #1; done_edges++;
    start = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b1; exp_pass = (m_sig == 3'b000);
    check("done_latency", done_edges, 65);
    check("test_mode_cycles", tm_cnt, 63);
    // abort in DONE is ignored
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic small_check();
    int n;
    st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; n = 0;
    while (!done1 && n < 10) begin @(posedge clk); #1; n++; end
    check("n1_done_edges", n, 3);
    check("n1_sig", sig1, 3'b111);
    check("n1_pass", pass1, 1'b1);
    st2 = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0; n = 0;
    while (!done2a && n < 10) begin @(posedge clk); #1; n++; end
    check("n2_done_edges", n, 4);
    check("n2a_sig", sig2a, 3'b010);
    check("n2a_pass", pass2a, 1'b1);
    check("n2b_done", done2b, 1'b1);
    check("n2b_sig", sig2b, 3'b010);
    check("n2b_pass", pass2b, 1'b0);
  endtask

  initial begin
    logic [2:0] first_sig;
    logic       first_pass;
    logic [5:0] first6 [6];
    bit         seen [64];
    int         distinct;
    first6 = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21};
    reset = 1'b1; start = 1'b0; abort = 1'b0; cut_in = 3'b000;
    no_abort = 1'b0; st1 = 1'b0; st2 = 1'b0; cut_ones = 3'b111;
    set_idle_reset_values();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Full 63-pattern run with zero responses
    main_run(0, 1'b0, -1, 1'b0);
    check("zero_run_pass", pass, 1'b1);
    for (int i = 0; i < 6; i++) check($sformatf("first_pat%0d", i), tpg_log[i], first6[i]);
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int i = 0; i < 63; i++) begin
      if (tpg_log[i] != 6'h00 && !seen[tpg_log[i]]) distinct++;
      seen[tpg_log[i]] = 1'b1;
    end
    check("distinct_nonzero_patterns", distinct, 63);

    // Random responses with start noise while busy, then a replay entered
    // from DONE with start and abort together
    main_run(1, 1'b0, -1, 1'b0);
    first_sig = m_sig; first_pass = (m_sig == 3'b000);
    main_run(2, 1'b1, -1, 1'b0);
    check("replay_sig", sig, first_sig);
    check("replay_pass", pass, first_pass);

    // Abort in RUN cycle 5
    main_run(1, 1'b0, 5, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset at pattern 10, then a normal full run
    main_run(0, 1'b0, 10, 1'b0 | 1'b1);
    main_run(0, 1'b0, -1, 1'b0);
    check("post_reset_pass", pass, 1'b1);
    check("post_reset_sig", sig, 3'b000);

    small_check();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
